// File: rtl/io_clk_wkup_pkg.sv
// Shared definitions for the wakeup-line detector: state encodings, default
// filter/timeout lengths and saturating counter helpers.
package io_clk_wkup_pkg;

    localparam int FILT_CYC_DEF = 4;
    localparam int TO_CYC_DEF   = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILT = 2'b01,
        ST_REQ  = 2'b10,
        ST_REL  = 2'b11
    } wkup_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for a single asynchronous level; reset clears both
// stages so nothing stale leaks out after reset release.
module io_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_clk_wkup_det.sv
// Wakeup-line detector: filters the synchronized shared line, raises a
// four-phase request to the consumer, and flags an acknowledge timeout.
module io_clk_wkup_det
    import io_clk_wkup_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF,
    parameter int TO_CYC   = TO_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drain_in,
    input  logic       en,
    input  logic       wkup_ack,
    input  logic       err_clr,
    output logic       wkup_req,
    output logic       wkup_active,
    output logic       wkup_err,
    output logic [1:0] state_o
);

    localparam logic [3:0] FILT_LIM = 4'(FILT_CYC);
    localparam logic [7:0] TO_LIM   = 8'(TO_CYC);

    wkup_state_e state, state_nxt;
    logic [3:0]  filt_cnt, filt_nxt, filt_inc;
    logic [7:0]  to_cnt, to_nxt, to_inc;
    logic        err_set;
    logic        line;

    io_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (drain_in),
        .q     (line)
    );

    // Thresholds compare the incremented count, so the cycle that reaches
    // the limit is the one that moves the state.
    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        to_nxt    = to_cnt;
        err_set   = 1'b0;
        filt_inc  = sat_inc4(filt_cnt);
        to_inc    = sat_inc8(to_cnt);
        if (!en) begin
            state_nxt = ST_IDLE;
            filt_nxt  = '0;
            to_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (line) begin
                        to_nxt = '0;
                        if (FILT_LIM <= 4'd1) begin
                            state_nxt = ST_REQ;
                            filt_nxt  = '0;
                        end else begin
                            state_nxt = ST_FILT;
                            filt_nxt  = 4'd1;
                        end
                    end
                end
                ST_FILT: begin
                    if (!line) begin
                        state_nxt = ST_IDLE;
                        filt_nxt  = '0;
                    end else if (filt_inc >= FILT_LIM) begin
                        state_nxt = ST_REQ;
                        filt_nxt  = '0;
                        to_nxt    = '0;
                    end else begin
                        filt_nxt = filt_inc;
                    end
                end
                ST_REQ: begin
                    to_nxt = to_inc;
                    if (wkup_ack) begin
                        state_nxt = ST_REL;
                        to_nxt    = '0;
                        filt_nxt  = '0;
                    end else if (to_inc >= TO_LIM) begin
                        err_set   = 1'b1;
                        state_nxt = ST_REL;
                        to_nxt    = '0;
                        filt_nxt  = '0;
                    end
                end
                ST_REL: begin
                    if (line) begin
                        filt_nxt = '0;
                    end else if ((filt_inc >= FILT_LIM) && !wkup_ack) begin
                        state_nxt = ST_IDLE;
                        filt_nxt  = '0;
                    end else begin
                        filt_nxt = filt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    filt_nxt  = '0;
                    to_nxt    = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state into their own flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            filt_cnt    <= '0;
            to_cnt      <= '0;
            wkup_req    <= 1'b0;
            wkup_active <= 1'b0;
            wkup_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            filt_cnt    <= filt_nxt;
            to_cnt      <= to_nxt;
            wkup_req    <= (state_nxt == ST_REQ);
            wkup_active <= state_nxt[1];
            wkup_err    <= err_set | (wkup_err & ~err_clr);
        end
    end

    assign state_o = state;

endmodule
